// File: rtl/pcie_pop_arbiter_pkg.sv
// Shared types and constants for the two-queue pop scheduler.
// Imported by the top level and the bench.
package pcie_pop_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

  localparam logic DEST_OUT0 = 1'b0;
  localparam logic DEST_OUT1 = 1'b1;

endpackage

// File: rtl/pcie_pop_arbiter_if.sv
// Bundle of upstream FWFT FIFO heads/pops and downstream FIFO pushes/back-pressure.
// The scheduler uses the slave side; the surrounding datapath uses the master side.
interface pcie_pop_arbiter_if #(
  parameter int DATA_SIZE = 8
);

  logic [DATA_SIZE-1:0] data_in0;
  logic [DATA_SIZE-1:0] data_in1;
  logic                 empty_in0;
  logic                 empty_in1;
  logic                 almost_full_out0;
  logic                 almost_full_out1;
  logic                 pop0;
  logic                 pop1;
  logic                 push_out0;
  logic                 push_out1;
  logic [DATA_SIZE-1:0] data_out0;
  logic [DATA_SIZE-1:0] data_out1;

  modport slave (
    input  data_in0, data_in1, empty_in0, empty_in1,
    input  almost_full_out0, almost_full_out1,
    output pop0, pop1, push_out0, push_out1, data_out0, data_out1
  );

  modport master (
    output data_in0, data_in1, empty_in0, empty_in1,
    output almost_full_out0, almost_full_out1,
    input  pop0, pop1, push_out0, push_out1, data_out0, data_out1
  );

endinterface

// File: rtl/pcie_pop_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: grants both when the requests do not conflict,
// otherwise alternates; the pointer always points at the requester not served alone last.
module pcie_pop_arbiter_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  input  logic conflict,
  output logic gnt0,
  output logic gnt1
);

  logic rr_ptr;
  logic rr_next;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rr_next = rr_ptr;
    if (en) begin
      if (req0 && req1) begin
        if (!conflict) begin
          gnt0 = 1'b1;
          gnt1 = 1'b1;
        end else begin
          gnt0    = ~rr_ptr;
          gnt1    = rr_ptr;
          rr_next = ~rr_ptr;
        end
      end else if (req0) begin
        gnt0    = 1'b1;
        rr_next = 1'b1;
      end else if (req1) begin
        gnt1    = 1'b1;
        rr_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
    end else begin
      rr_ptr <= rr_next;
    end
  end

endmodule

// File: rtl/pcie_pop_arbiter.sv
// Pops up to two upstream FWFT heads per cycle and routes each word to the
// downstream FIFO chosen by its destination bit, honouring almost_full back-pressure.
module pcie_pop_arbiter
  import pcie_pop_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int DEST_BIT  = 7,
  parameter int CNT_SIZE  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  pcie_pop_arbiter_if.slave   bus,
  output logic                active,
  output logic [CNT_SIZE-1:0] xfer_cnt0,
  output logic [CNT_SIZE-1:0] xfer_cnt1
);

  state_t               state;
  state_t               state_next;
  logic                 dest0;
  logic                 dest1;
  logic                 elig0;
  logic                 elig1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 route0;
  logic                 route1;
  logic [DATA_SIZE-1:0] word0;
  logic [DATA_SIZE-1:0] word1;
  logic                 any_head;

  assign dest0    = bus.data_in0[DEST_BIT];
  assign dest1    = bus.data_in1[DEST_BIT];
  assign elig0    = !bus.empty_in0 &&
                    !((dest0 == DEST_OUT1) ? bus.almost_full_out1 : bus.almost_full_out0);
  assign elig1    = !bus.empty_in1 &&
                    !((dest1 == DEST_OUT1) ? bus.almost_full_out1 : bus.almost_full_out0);
  assign any_head = !bus.empty_in0 || !bus.empty_in1;

  pcie_pop_arbiter_rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .en       (state == ST_ACTIVE),
    .req0     (elig0),
    .req1     (elig1),
    .conflict (dest0 == dest1),
    .gnt0     (gnt0),
    .gnt1     (gnt1)
  );

  // Pops are gated by reset as well so nothing is consumed while reset is held.
  assign bus.pop0 = gnt0 && reset;
  assign bus.pop1 = gnt1 && reset;
  assign active   = (state == ST_ACTIVE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (bus.almost_full_out0 && bus.almost_full_out1 && any_head) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (!bus.almost_full_out0 || !bus.almost_full_out1) begin
          state_next = ST_ACTIVE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A dual grant only happens for differing destinations, so each output sees at most one word.
  always_comb begin
    route0 = (gnt0 && dest0 == DEST_OUT0) || (gnt1 && dest1 == DEST_OUT0);
    route1 = (gnt0 && dest0 == DEST_OUT1) || (gnt1 && dest1 == DEST_OUT1);
    word0  = (gnt0 && dest0 == DEST_OUT0) ? bus.data_in0 : bus.data_in1;
    word1  = (gnt0 && dest0 == DEST_OUT1) ? bus.data_in0 : bus.data_in1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.push_out0 <= 1'b0;
      bus.push_out1 <= 1'b0;
      bus.data_out0 <= '0;
      bus.data_out1 <= '0;
      xfer_cnt0     <= '0;
      xfer_cnt1     <= '0;
    end else begin
      bus.push_out0 <= route0;
      bus.push_out1 <= route1;
      if (route0) begin
        bus.data_out0 <= word0;
        xfer_cnt0     <= xfer_cnt0 + CNT_SIZE'(1);
      end
      if (route1) begin
        bus.data_out1 <= word1;
        xfer_cnt1     <= xfer_cnt1 + CNT_SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_pcie_pop_arbiter.sv
// Directed bench for pcie_pop_arbiter: a queue-level reference model checked every
// cycle on the falling edge, plus hand-computed expectations at key points.
module tb_pcie_pop_arbiter;

  localparam int DATA_SIZE = 8;
  localparam int DEST_BIT  = 7;
  localparam int CNT_SIZE  = 8;
  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSE   = 2;

  logic                clk    = 1'b0;
  logic                reset  = 1'b1;
  logic                enable = 1'b0;
  logic                active;
  logic [CNT_SIZE-1:0] xfer_cnt0;
  logic [CNT_SIZE-1:0] xfer_cnt1;

  int vec_count  = 0;
  int miscompares = 0;

  int                   m_mode;
  int                   m_rr;
  logic                 m_push0;
  logic                 m_push1;
  logic [DATA_SIZE-1:0] m_dout0;
  logic [DATA_SIZE-1:0] m_dout1;
  logic [CNT_SIZE-1:0]  m_cnt0;
  logic [CNT_SIZE-1:0]  m_cnt1;

  pcie_pop_arbiter_if #(.DATA_SIZE(DATA_SIZE)) bus ();

  pcie_pop_arbiter #(
    .DATA_SIZE (DATA_SIZE),
    .DEST_BIT  (DEST_BIT),
    .CNT_SIZE  (CNT_SIZE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .active    (active),
    .xfer_cnt0 (xfer_cnt0),
    .xfer_cnt1 (xfer_cnt1)
  );

  always #5 clk = ~clk;

  // Which queues the rules allow to pop right now; bit0 = queue 0, bit1 = queue 1.
  function automatic logic [1:0] model_grant();
    logic       el0;
    logic       el1;
    logic [1:0] g;
    el0 = !bus.empty_in0 &&
          !(bus.data_in0[DEST_BIT] ? bus.almost_full_out1 : bus.almost_full_out0);
    el1 = !bus.empty_in1 &&
          !(bus.data_in1[DEST_BIT] ? bus.almost_full_out1 : bus.almost_full_out0);
    g = 2'b00;
    if (m_mode == M_RUN && reset) begin
      if (el0 && el1) begin
        if (bus.data_in0[DEST_BIT] != bus.data_in1[DEST_BIT]) g = 2'b11;
        else g = (m_rr == 0) ? 2'b01 : 2'b10;
      end else begin
        g = {el1, el0};
      end
    end
    return g;
  endfunction

  function automatic logic grants_to(input logic o);
    logic [1:0] g;
    g = model_grant();
    return (g[0] && bus.data_in0[DEST_BIT] == o) || (g[1] && bus.data_in1[DEST_BIT] == o);
  endfunction

  function automatic logic [DATA_SIZE-1:0] word_for(input logic o);
    logic [1:0] g;
    g = model_grant();
    return (g[0] && bus.data_in0[DEST_BIT] == o) ? bus.data_in0 : bus.data_in1;
  endfunction

  function automatic int next_rr();
    logic [1:0] g;
    g = model_grant();
    if (g == 2'b01) return 1;
    if (g == 2'b10) return 0;
    return m_rr;
  endfunction

  function automatic int next_mode();
    logic both_full;
    both_full = bus.almost_full_out0 && bus.almost_full_out1;
    if (m_mode == M_IDLE) return enable ? M_RUN : M_IDLE;
    if (!enable) return M_IDLE;
    if (m_mode == M_RUN)
      return (both_full && (!bus.empty_in0 || !bus.empty_in1)) ? M_PAUSE : M_RUN;
    return both_full ? M_PAUSE : M_RUN;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode  <= M_IDLE;
      m_rr    <= 0;
      m_push0 <= 1'b0;
      m_push1 <= 1'b0;
      m_dout0 <= '0;
      m_dout1 <= '0;
      m_cnt0  <= '0;
      m_cnt1  <= '0;
    end else begin
      m_push0 <= grants_to(1'b0);
      m_push1 <= grants_to(1'b1);
      if (grants_to(1'b0)) begin
        m_dout0 <= word_for(1'b0);
        m_cnt0  <= m_cnt0 + 8'd1;
      end
      if (grants_to(1'b1)) begin
        m_dout1 <= word_for(1'b1);
        m_cnt1  <= m_cnt1 + 8'd1;
      end
      m_rr   <= next_rr();
      m_mode <= next_mode();
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compare_all();
    logic [1:0] g;
    g = model_grant();
    check_output("pop0", 32'(bus.pop0), 32'(g[0]));
    check_output("pop1", 32'(bus.pop1), 32'(g[1]));
    check_output("push_out0", 32'(bus.push_out0), 32'(m_push0));
    check_output("push_out1", 32'(bus.push_out1), 32'(m_push1));
    check_output("data_out0", 32'(bus.data_out0), 32'(m_dout0));
    check_output("data_out1", 32'(bus.data_out1), 32'(m_dout1));
    check_output("xfer_cnt0", 32'(xfer_cnt0), 32'(m_cnt0));
    check_output("xfer_cnt1", 32'(xfer_cnt1), 32'(m_cnt1));
    check_output("active", 32'(active), 32'(m_mode == M_RUN));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus();
    #1 reset = 1'b0;
    tick();
    tick();
    check_output("rst_pop0", 32'(bus.pop0), 32'd0);
    check_output("rst_push0", 32'(bus.push_out0), 32'd0);
    check_output("rst_cnt0", 32'(xfer_cnt0), 32'd0);
    check_output("rst_active", 32'(active), 32'd0);
    reset = 1'b1;
    tick();
    check_output("first_pop0", 32'(bus.pop0), 32'd1);
    check_output("first_active", 32'(active), 32'd1);
    tick();
    bus.empty_in0 = 1'b1;
    check_output("first_push0", 32'(bus.push_out0), 32'd1);
    check_output("first_data0", 32'(bus.data_out0), 32'h05);
    check_output("first_cnt0", 32'(xfer_cnt0), 32'd1);

    // Differing destinations: both heads go in the same cycle.
    bus.data_in0 = 8'h81; bus.data_in1 = 8'h02;
    bus.empty_in0 = 1'b0; bus.empty_in1 = 1'b0;
    #1;
    check_output("dual_pop0", 32'(bus.pop0), 32'd1);
    check_output("dual_pop1", 32'(bus.pop1), 32'd1);
    tick();
    bus.empty_in0 = 1'b1; bus.empty_in1 = 1'b1;
    check_output("dual_push0", 32'(bus.push_out0), 32'd1);
    check_output("dual_push1", 32'(bus.push_out1), 32'd1);
    check_output("dual_data0", 32'(bus.data_out0), 32'h02);
    check_output("dual_data1", 32'(bus.data_out1), 32'h81);
    check_output("dual_cnt0", 32'(xfer_cnt0), 32'd2);
    check_output("dual_cnt1", 32'(xfer_cnt1), 32'd1);

    // A lone pop of queue 1 points the round-robin back at queue 0.
    bus.data_in1 = 8'h03; bus.empty_in1 = 1'b0;
    tick();
    bus.data_in0 = 8'h04; bus.data_in1 = 8'h06;
    bus.empty_in0 = 1'b0; bus.empty_in1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_output("rr_pop0", 32'(bus.pop0), 32'(k % 2 == 0));
      check_output("rr_pop1", 32'(bus.pop1), 32'(k % 2 == 1));
      tick();
    end

    bus.almost_full_out0 = 1'b1;
    #1;
    check_output("af_pop0", 32'(bus.pop0), 32'd0);
    check_output("af_pop1", 32'(bus.pop1), 32'd0);
    check_output("af_active", 32'(active), 32'd1);
    tick();
    bus.almost_full_out1 = 1'b1;
    tick();
    check_output("pause_active", 32'(active), 32'd0);
    check_output("pause_pop0", 32'(bus.pop0), 32'd0);
    bus.almost_full_out1 = 1'b0;
    tick();
    check_output("resume_active", 32'(active), 32'd1);
    bus.almost_full_out0 = 1'b0;
    bus.empty_in0 = 1'b1; bus.empty_in1 = 1'b1;
    tick();

    // Dropping enable still lets the last ACTIVE pop land.
    bus.data_in0 = 8'h05; bus.empty_in0 = 1'b0;
    enable = 1'b0;
    #1;
    check_output("ef_last_pop0", 32'(bus.pop0), 32'd1);
    tick();
    check_output("ef_idle_pop0", 32'(bus.pop0), 32'd0);
    check_output("ef_active", 32'(active), 32'd0);
    check_output("ef_push0", 32'(bus.push_out0), 32'd1);
    check_output("ef_data0", 32'(bus.data_out0), 32'h05);
    tick();
    check_output("ef_push0_drop", 32'(bus.push_out0), 32'd0);
    check_output("ef_data0_hold", 32'(bus.data_out0), 32'h05);
    bus.empty_in0 = 1'b1;
    enable = 1'b1;
    tick();

    // Asynchronous reset in the middle of a dual grant.
    bus.data_in0 = 8'h81; bus.data_in1 = 8'h02;
    bus.empty_in0 = 1'b0; bus.empty_in1 = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    check_output("ar_pop0", 32'(bus.pop0), 32'd0);
    check_output("ar_pop1", 32'(bus.pop1), 32'd0);
    check_output("ar_push0", 32'(bus.push_out0), 32'd0);
    check_output("ar_push1", 32'(bus.push_out1), 32'd0);
    check_output("ar_cnt0", 32'(xfer_cnt0), 32'd0);
    check_output("ar_cnt1", 32'(xfer_cnt1), 32'd0);
    bus.empty_in0 = 1'b1; bus.empty_in1 = 1'b1;
    tick();
    reset = 1'b1;
    tick();

    // 256 pushes to output 0 wrap its counter.
    bus.data_in0 = 8'h10; bus.empty_in0 = 1'b0;
    repeat (255) tick();
    check_output("wrap_ff", 32'(xfer_cnt0), 32'hFF);
    tick();
    check_output("wrap_00", 32'(xfer_cnt0), 32'h00);
    bus.empty_in0 = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    enable               = 1'b1;
    bus.data_in0         = 8'h05;
    bus.data_in1         = 8'h00;
    bus.empty_in0        = 1'b0;
    bus.empty_in1        = 1'b1;
    bus.almost_full_out0 = 1'b0;
    bus.almost_full_out1 = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
      apply_stimulus();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
